hams_merge_drain_accum: RTL

//  Read-side companion of the 4-to-1 merge sorter. Drains its FWFT output FIFO by driving fifo_pop.

---
 rtl/hams_pkg.sv | 21 ++
 rtl/hams_val_adder.sv | 32 +++
 rtl/hams_merge_drain_accum.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hams_pkg.sv
// Shared types for the merge sorter read side: the sorted (key, value) pair
// and the drain FSM states.
package hams_pkg;

  localparam int unsigned INFO_W = 16;
  localparam int unsigned VAL_W  = 16;

  // One sorted element: info is the key (compared unsigned), val is the payload.
  typedef struct packed {
    logic [INFO_W-1:0] info;
    logic [VAL_W-1:0]  val;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    FIN
  } drain_state_e;

endpackage

// File: rtl/hams_val_adder.sv
// Value adder for merging equal keys.
// Build option HAMS_ACCUM_SAT_EN: clamp at all-ones and report the clamp on o_sat;
// without it the add wraps modulo 2^VAL_W and o_sat does not exist.
module hams_val_adder
  import hams_pkg::*;
(
  input  logic [VAL_W-1:0] i_a,
  input  logic [VAL_W-1:0] i_b,
  output logic [VAL_W-1:0] o_sum
`ifdef HAMS_ACCUM_SAT_EN
  ,
  output logic             o_sat
`endif
);

`ifdef HAMS_ACCUM_SAT_EN
  logic [VAL_W:0] w_full;

  // Widened add; the carry-out marks an overflow that gets clamped.
  always_comb begin
    w_full = {1'b0, i_a} + {1'b0, i_b};
    o_sat  = w_full[VAL_W];
    o_sum  = w_full[VAL_W] ? {VAL_W{1'b1}} : w_full[VAL_W-1:0];
  end
`else
  // Plain modulo add.
  always_comb begin
    o_sum = i_a + i_b;
  end
`endif

endmodule

// File: rtl/hams_merge_drain_accum.sv
// Read-side companion of the 4-to-1 merge sorter. Pops the sorter's FWFT FIFO,
// merges runs of equal keys by summing their values and emits the compacted
// stream on a valid/ready port. A flush pulse drains the hold register and ends
// with a one-cycle done pulse, after which out_count restarts from zero.
// Build option HAMS_ACCUM_SAT_EN: saturating accumulation plus sticky sat_flag.
module hams_merge_drain_accum
  import hams_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  pair_t            sort_data_i,
  output logic             fifo_pop,
  input  logic             flush,
  input  logic             out_rdy,
  output logic             out_vld,
  output pair_t            out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             order_err,
  output logic             done
`ifdef HAMS_ACCUM_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  drain_state_e     r_state;
  pair_t            r_hold;
  logic             r_hold_vld;
  logic             r_flush_pend;
  pair_t            r_out_data;
  logic             r_out_vld;
  logic [CNT_W-1:0] r_out_count;
  logic             r_order_err;
  logic             r_done;
`ifdef HAMS_ACCUM_SAT_EN
  logic             r_sat_flag;
  logic             w_sat;
`endif

  logic             w_out_free;
  logic             w_hs;
  logic             w_key_eq;
  logic             w_key_lt;
  logic             w_flush_any;
  logic             w_pop;
  logic [VAL_W-1:0] w_sum;

  // Output slot can take a new element, handshake, and key relation of head vs hold.
  always_comb begin
    w_out_free  = !r_out_vld || out_rdy;
    w_hs        = r_out_vld && out_rdy;
    w_key_eq    = (sort_data_i.info == r_hold.info);
    w_key_lt    = (sort_data_i.info < r_hold.info);
    w_flush_any = flush || r_flush_pend;
  end

  // Pop decision: an equal key always merges; a new key needs a free output slot.
  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      IDLE:    w_pop = !fifo_empty;
      ACC:     w_pop = r_hold_vld && !fifo_empty && (w_key_eq || w_out_free);
      DRAIN:   w_pop = 1'b0;
      FIN:     w_pop = 1'b0;
      default: w_pop = 1'b0;
    endcase
  end

  hams_val_adder u_val_adder (
    .i_a   (r_hold.val),
    .i_b   (sort_data_i.val),
    .o_sum (w_sum)
`ifdef HAMS_ACCUM_SAT_EN
    ,
    .o_sat (w_sat)
`endif
  );

  // Drain FSM with hold register, output register, counter and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_hold_vld   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_out_data   <= '0;
      r_out_vld    <= 1'b0;
      r_out_count  <= '0;
      r_order_err  <= 1'b0;
      r_done       <= 1'b0;
`ifdef HAMS_ACCUM_SAT_EN
      r_sat_flag   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;

      // The count restarts the cycle after done; no handshake can coincide with it
      // because the output slot is empty once FIN exits.
      if (r_done) begin
        r_out_count <= '0;
      end else if (w_hs) begin
        r_out_count <= r_out_count + 1'b1;
      end

      // A completed handshake empties the slot unless a new element lands below.
      if (w_hs) begin
        r_out_vld <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (!fifo_empty) begin
            r_hold       <= sort_data_i;
            r_hold_vld   <= 1'b1;
            r_flush_pend <= flush;
            r_state      <= ACC;
          end else if (flush) begin
            r_state <= FIN;
          end
        end

        ACC: begin
          if (!fifo_empty) begin
            if (flush) begin
              r_flush_pend <= 1'b1;
            end
            if (w_key_lt) begin
              r_order_err <= 1'b1;
            end
            if (w_key_eq) begin
              r_hold.val <= w_sum;
`ifdef HAMS_ACCUM_SAT_EN
              if (w_sat) begin
                r_sat_flag <= 1'b1;
              end
`endif
            end else if (w_out_free) begin
              r_out_data <= r_hold;
              r_out_vld  <= 1'b1;
              r_hold     <= sort_data_i;
            end
          end else if (w_flush_any) begin
            r_flush_pend <= 1'b0;
            r_state      <= DRAIN;
          end
        end

        DRAIN: begin
          if (w_out_free) begin
            r_out_data <= r_hold;
            r_out_vld  <= 1'b1;
            r_hold_vld <= 1'b0;
            r_state    <= FIN;
          end
        end

        FIN: begin
          if (w_out_free) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // Everything visible downstream comes straight from registers except the pop.
  always_comb begin
    fifo_pop  = w_pop;
    out_vld   = r_out_vld;
    out_data  = r_out_data;
    out_count = r_out_count;
    order_err = r_order_err;
    done      = r_done;
`ifdef HAMS_ACCUM_SAT_EN
    sat_flag  = r_sat_flag;
`endif
  end

endmodule
